shift_left: RTL and testbench
=============================

Name: shift_left

Overview:
- Registered, parameterised left shifter. Default operation is a constant shift by 2, which is word-to-byte address scaling for branch and jump offsets in the datapath.
- An optional variable shift amount turns it into a general logical barrel shifter.
- Output is registered, with a valid flag and an overflow (bits-lost) flag.

Parameters:
- N, 32, data width in bits (N >= 2).
- SHAMT_W, $clog2(N), width of the variable shift-amount input.
- DEFAULT_SHIFT, 2, shift amount used when use_shamt = 0 (0 <= DEFAULT_SHIFT < N).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- A  input  N  operand to shift.
- in_valid  input  1  A and the controls are sampled this cycle.
- use_shamt  input  1  1: shift by shamt; 0: shift by DEFAULT_SHIFT.
- shamt  input  SHAMT_W  variable shift amount.
- B  output  N  shifted result.
- out_valid  output  1  B and ovf are valid.
- ovf  output  1  at least one 1-bit was shifted out of the MSB end.

Behaviour:
- Reset: while reset is sampled high, B <= 0, ovf <= 0, out_valid <= 0. Reset has priority over in_valid in the same cycle.
- Latency is 1 cycle. If in_valid is high at edge k, then after edge k: B = A << s (logical), vacated LSBs are 0, and out_valid = 1.
- Shift amount s is shamt if use_shamt = 1, else DEFAULT_SHIFT.
- If in_valid is low at an edge: out_valid <= 0, and B and ovf hold their previous values.
- No back-pressure. A new operand is accepted every cycle.
- ovf = OR of A[N-1 : N-s]. When s = 0, ovf = 0.
- Width rules: result is truncated to N bits, with no sign extension or saturation.
- shamt values >= N are impossible when N is a power of two. Otherwise they produce B = 0, with ovf = |A.
- s = N-1 moves A[0] to B[N-1] and clears all other bits.
- Reset mid-stream: an operand captured on the same edge as reset is discarded.

Optional Feature:
- Macro SHIFT_LEFT_ROTATE_EN.
- When defined:
  - Adds input port rotate (1 bit).
  - When rotate = 1, B = A rotated left by s: bits leaving the MSB re-enter at the LSB.
  - ovf is forced to 0 during a rotate.
  - With rotate = 0, behaviour is identical to the base block.
- When undefined: no rotate port; logical shift only.

Decomposition:
- Package shift_left_pkg:
  - localparams for default width (32) and DEFAULT_SHIFT (2).
  - typedef shift_mode_e {SHL_LOGICAL, SHL_ROTATE}.
- Sub-module shift_left_barrel:
  - Purely combinational log2(N)-stage mux barrel shifter.
  - Inputs: data, amount, mode. Outputs: shifted data and lost-bit OR.
- Top module shift_left holds only the amount select, the output registers and the valid/reset logic.

Test Plan:
- Reset held 2 cycles, with A = 0xFFFFFFFF and in_valid = 1 -> B = 0, ovf = 0, out_valid = 0 throughout.
- Default shift, use_shamt = 0, A = 0, 45, 290 on consecutive cycles -> B = 0, 180, 1160 one cycle later each, ovf = 0, out_valid = 1.
- Overflow: A = 0xC0000001, use_shamt = 0 -> B = 0x00000004, ovf = 1.
- Variable shift: A = 1, shamt = 31 -> B = 0x80000000, ovf = 0. Then A = 0xFFFF, shamt = 0 -> B = 0xFFFF, ovf = 0.
- Hold: in_valid drops after A = 45 -> out_valid = 0 and B stays 180 on later cycles.
- With SHIFT_LEFT_ROTATE_EN: A = 0x80000001, rotate = 1, shamt = 4 -> B = 0x00000018, ovf = 0.

Source files
------------

// File: rtl/shift_left_pkg.sv
// Shared definitions for the shift_left block: default geometry and the
// shift-mode encoding used between the top and the barrel core.
package shift_left_pkg;

    localparam int SHL_DEFAULT_WIDTH = 32;
    localparam int SHL_DEFAULT_SHIFT = 2;

    typedef enum logic {
        SHL_LOGICAL = 1'b0,
        SHL_ROTATE  = 1'b1
    } shift_mode_e;

endpackage

// File: rtl/shift_left_barrel.sv
// Combinational log2(N)-stage barrel shifter. Stage i moves the word left by
// 2**i when amount[i] is set. In logical mode the bits pushed past the MSB are
// OR-ed into lost. If amount >= N (only possible when N is not a power of two),
// the stages together push every bit out, so the result is 0 and lost = |data.
// In rotate mode the bits re-enter at the LSB and lost stays 0.
module shift_left_barrel
    import shift_left_pkg::*;
#(
    parameter int N       = SHL_DEFAULT_WIDTH,
    parameter int SHAMT_W = $clog2(N)
) (
    input  logic [N-1:0]       data,
    input  logic [SHAMT_W-1:0] amount,
    input  shift_mode_e        mode,
    output logic [N-1:0]       result,
    output logic               lost
);

    logic [N-1:0] cur_s;
    logic         lost_s;

    // Cascade of power-of-two shift stages; every stage shift (2**i) is < N.
    always_comb begin
        cur_s  = data;
        lost_s = 1'b0;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (amount[i]) begin
                case (mode)
                    SHL_ROTATE: begin
                        cur_s = (cur_s << (32'd1 << i)) | (cur_s >> (N - (32'd1 << i)));
                    end
                    SHL_LOGICAL: begin
                        lost_s = lost_s | (|(cur_s >> (N - (32'd1 << i))));
                        cur_s  = cur_s << (32'd1 << i);
                    end
                    default: begin
                        cur_s  = {N{1'b0}};
                        lost_s = 1'b0;
                    end
                endcase
            end else begin
                // Stage bypassed: the word passes through unchanged.
                cur_s = cur_s;
            end
        end
    end

    assign result = cur_s;
    assign lost   = lost_s;

endmodule

// File: rtl/shift_left.sv
// Registered left shifter. Default use is a constant shift by DEFAULT_SHIFT
// (word-to-byte address scaling); use_shamt selects a variable amount.
// Optional macro SHIFT_LEFT_ROTATE_EN adds a rotate input that turns the shift
// into a left rotation (ovf forced to 0 while rotating).
module shift_left
    import shift_left_pkg::*;
#(
    parameter int N             = SHL_DEFAULT_WIDTH,
    parameter int SHAMT_W       = $clog2(N),
    parameter int DEFAULT_SHIFT = SHL_DEFAULT_SHIFT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       A,
    input  logic               in_valid,
    input  logic               use_shamt,
    input  logic [SHAMT_W-1:0] shamt,
`ifdef SHIFT_LEFT_ROTATE_EN
    input  logic               rotate,
`endif
    output logic [N-1:0]       B,
    output logic               out_valid,
    output logic               ovf
);

    logic [SHAMT_W-1:0] amount_s;
    shift_mode_e        mode_s;
    logic [N-1:0]       shifted_s;
    logic               lost_s;
    logic               ovf_next_s;

    // Pick the shift amount: variable input or the fixed scaling constant.
    always_comb begin
        if (use_shamt) begin
            amount_s = shamt;
        end else begin
            amount_s = SHAMT_W'(DEFAULT_SHIFT);
        end
    end

    // Pick the shift mode; without the rotate option it is always logical.
    always_comb begin
`ifdef SHIFT_LEFT_ROTATE_EN
        if (rotate) begin
            mode_s = SHL_ROTATE;
        end else begin
            mode_s = SHL_LOGICAL;
        end
`else
        mode_s = SHL_LOGICAL;
`endif
    end

    shift_left_barrel #(
        .N       (N),
        .SHAMT_W (SHAMT_W)
    ) u_barrel (
        .data   (A),
        .amount (amount_s),
        .mode   (mode_s),
        .result (shifted_s),
        .lost   (lost_s)
    );

    // Overflow only has meaning for a logical shift; rotation loses nothing.
    always_comb begin
        if (mode_s == SHL_LOGICAL) begin
            ovf_next_s = lost_s;
        end else begin
            ovf_next_s = 1'b0;
        end
    end

    // Output registers: reset wins, a valid operand loads, otherwise hold data.
    always_ff @(posedge clk) begin
        if (reset) begin
            B         <= {N{1'b0}};
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            B         <= shifted_s;
            ovf       <= ovf_next_s;
            out_valid <= 1'b1;
        end else begin
            B         <= B;
            ovf       <= ovf;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_left.sv
// Scoreboard bench for shift_left (N = 32). The driver computes the expected
// registered state for every edge from plain arithmetic and queues it; the
// monitor pops one entry per cycle on the falling edge and compares.
module tb_shift_left;

    localparam int N = 32;

    typedef struct {
        logic        v;
        logic [31:0] b;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A;
    logic        in_valid;
    logic        use_shamt;
    logic [4:0]  shamt;
    logic        rot;
    logic [31:0] B;
    logic        out_valid;
    logic        ovf;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // model state: what the output registers should hold
    logic [31:0] m_b = 32'd0;
    logic        m_o = 1'b0;
    logic        m_v = 1'b0;

    always #5 clk = ~clk;

    shift_left dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .in_valid  (in_valid),
        .use_shamt (use_shamt),
        .shamt     (shamt),
`ifdef SHIFT_LEFT_ROTATE_EN
        .rotate    (rot),
`endif
        .B         (B),
        .out_valid (out_valid),
        .ovf       (ovf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: shift the operand as a 64-bit number and split kept/lost halves.
    function automatic void ref_shift(input logic [31:0] a, input logic us,
                                      input logic [4:0] sh, input logic r,
                                      output logic [31:0] b, output logic o);
        int s;
        logic [63:0] full;
        s = us ? int'(sh) : 2;
        if (r) begin
            s = s % N;
            b = (s == 0) ? a : ((a << s) | (a >> (N - s)));
            o = 1'b0;
        end else begin
            full = {32'd0, a} << s;
            b = full[31:0];
            o = |full[63:32];
        end
    endfunction

    // Push the expected state after the coming edge, then advance one cycle.
    task automatic step();
        exp_t e;
        logic [31:0] nb;
        logic no;
        if (reset) begin
            m_b = 32'd0; m_o = 1'b0; m_v = 1'b0;
        end else if (in_valid) begin
            ref_shift(A, use_shamt, shamt, rot, nb, no);
            m_b = nb; m_o = no; m_v = 1'b1;
        end else begin
            m_v = 1'b0;
        end
        e.v = m_v; e.b = m_b; e.o = m_o;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic us, input logic [4:0] sh, input logic r);
        A = a; use_shamt = us; shamt = sh; rot = r; in_valid = 1'b1;
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        A = $urandom;
        step();
    endtask

    // Monitor: one expected entry per captured edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out_valid", {31'd0, out_valid}, {31'd0, e.v});
                chk("B", B, e.b);
                chk("ovf", {31'd0, ovf}, {31'd0, e.o});
            end
        end
    end

    initial begin
        reset = 1'b1; in_valid = 1'b1; A = 32'hFFFF_FFFF;
        use_shamt = 1'b0; shamt = 5'd0; rot = 1'b0;
        step();
        step();
        reset = 1'b0;

        put(32'd0, 1'b0, 5'd0, 1'b0);
        put(32'd45, 1'b0, 5'd0, 1'b0);
        put(32'd290, 1'b0, 5'd0, 1'b0);
        put(32'hC000_0001, 1'b0, 5'd0, 1'b0);
        put(32'h0000_0001, 1'b1, 5'd31, 1'b0);
        put(32'h0000_FFFF, 1'b1, 5'd0, 1'b0);
        put(32'h8000_0000, 1'b1, 5'd1, 1'b0);
        put(32'd45, 1'b0, 5'd0, 1'b0);
        idle();
        idle();
        idle();
`ifdef SHIFT_LEFT_ROTATE_EN
        put(32'h8000_0001, 1'b1, 5'd4, 1'b1);
        put(32'hF000_000F, 1'b0, 5'd0, 1'b1);
        put(32'h1234_5678, 1'b1, 5'd0, 1'b1);
        put(32'hC000_0001, 1'b0, 5'd0, 1'b0);
`endif
        // reset on the same edge as a valid operand: operand discarded
        put(32'h0000_0003, 1'b0, 5'd0, 1'b0);
        reset = 1'b1;
        put(32'hFFFF_FFFF, 1'b1, 5'd7, 1'b0);
        reset = 1'b0;
        idle();

        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 40) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0: A = 32'd0;
                1: A = 32'hFFFF_FFFF;
                2: A = 32'd1 << $urandom_range(0, 31);
                default: A = $urandom;
            endcase
            use_shamt = $urandom_range(0, 1) == 1;
            shamt     = 5'($urandom_range(0, 31));
`ifdef SHIFT_LEFT_ROTATE_EN
            rot       = $urandom_range(0, 1) == 1;
`else
            rot       = 1'b0;
`endif
            step();
        end
        reset = 1'b0;
        idle();
        idle();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
